timer_period_seq: RTL and testbench
===================================

# timer_period_seq

Upstream sequencer for the countdown timer. It queues reload periods from a producer through a valid/ready FIFO and drives the timer's `value`/`valid`/`enable` inputs. It watches the timer's `count` to detect expiry and loads the next queued period back-to-back. It also raises a one-cycle `period_done` pulse for each completed period, and supports pause and abort.

## Interface
Parameters:
- `WIDTH`, default 5: period/count width; matches the timer's `value` and `count` ports.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `in_period`, input, WIDTH: period to enqueue.
- `in_valid`, input, 1: producer offers `in_period`.
- `in_ready`, output, 1: `!full && !abort`. A push happens on `in_valid && in_ready`.
- `run`, input, 1: high permits loading and counting; low pauses.
- `abort`, input, 1: flush the queue and clear the timer.
- `timer_count`, input, WIDTH: the timer's `count` output.
- `value`, output, WIDTH: to timer `value`.
- `valid`, output, 1: to timer `valid`; one-cycle load strobe.
- `enable`, output, 1: to timer `enable`.
- `period_done`, output, 1: one-cycle pulse per completed period.
- `busy`, output, 1: high when state is not IDLE.
- `level`, output, $clog2(DEPTH+1): FIFO occupancy.

## Operation
- States: IDLE, LOAD, RUN, CLEAR. Encoding is 2-bit.
- IDLE:
  - `valid=0`, `enable=0`.
  - Goes to LOAD when `run && level!=0`.
- LOAD:
  - `valid=1`, `value=` FIFO head.
  - The head is popped at the end of the cycle and copied into `last_period`.
  - Always goes to RUN.
- RUN:
  - `valid=0`, `enable=run`.
  - When `timer_count==0`, the period is complete:
    - Goes to LOAD if `run && level!=0`.
    - Otherwise goes to IDLE.
    - `period_done` is registered high on the next cycle.
  - With `run=0`, the state holds in RUN and the count is frozen.
  - A count of 0 completes even while `run=0`. The next load waits for `run`.
- CLEAR:
  - Entered from any state when `abort=1`.
  - `valid=1`, `value=0`, so the timer is zeroed.
  - The FIFO is flushed and `level` becomes 0 on the same edge.
  - Goes to IDLE on the next cycle. `abort` held high keeps the block in CLEAR.
- Priority: `reset` > `abort` > normal FSM.
- A queued period of 0 is legal. The block spends one LOAD cycle, then one RUN cycle, then completes.
- FIFO behaviour:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - `level` is updated as +1 on push, −1 on pop, and unchanged on simultaneous push and pop.
  - When full, `in_ready=0` even if a pop happens in the same cycle.
  - When empty, no pop occurs, because LOAD is only entered with `level!=0`.
- Outputs are registered, except `in_ready` and `enable`, which are combinational from state and inputs.

## Timing
- Reset values: `valid=0`, `value=0`, `enable=0`, `period_done=0`, `busy=0`, `level=0`, state IDLE.
  - `in_ready` follows `!abort` while `reset` is asserted.
- Push to load:
  - A push at edge t makes `level=1` from t.
  - IDLE enters LOAD at t+1 if `run=1`.
  - The timer holds the new count from t+2.
- Back-to-back periods:
  - The RUN cycle that sees `count==0` is followed by LOAD, then RUN.
  - The gap between periods is 2 cycles per reload: one cycle at count 0 and one LOAD cycle.
- `period_done` rises on the cycle after RUN observes `timer_count==0`. It is exactly 1 cycle wide.
- Abort:
  - CLEAR is entered on the cycle after `abort` is sampled.
  - `valid`/`value=0` is presented in CLEAR, and the timer count is 0 on the following cycle.
  - No `period_done` is generated for an aborted period.
- An async `reset` mid-period returns all outputs to reset values immediately. The queued periods are lost.

## Configuration
- `TIMER_PERIOD_SEQ_REPEAT_EN`
  - Defined: on completion in RUN with `level==0` and `run=1`, the FSM goes to LOAD using `last_period`, which repeats the final period indefinitely. Abort, or `run=0` at completion, ends the repetition.
  - Undefined: the FSM goes to IDLE when the queue drains. The `last_period` register is still present for LOAD but is not used for reloading.

## Structure
- Shared package `timer_pkg`:
  - `TIMER_WIDTH=5`.
  - State typedef `seq_state_t` with values IDLE/LOAD/RUN/CLEAR.
- Sub-module `timer_period_fifo`, a parameterised WIDTH×DEPTH synchronous FIFO:
  - Ports: push, pop, flush, full, empty, level, head.
  - `timer_period_seq` instantiates it together with its FSM.

## Test plan
- Reset, push 3, `run=1`:
  - `valid` pulses with `value=3` two cycles after the push.
  - The timer counts 3→0.
  - `period_done` pulses once.
  - `busy` falls.
- Push 2, 1, 0, 5 with `run=1`:
  - Four `valid` strobes in order.
  - Four `period_done` pulses.
  - The value 0 completes one cycle after its load.
- Fill to DEPTH=4 with `run=0`:
  - `in_ready=0` and `level=4`.
  - A fifth `in_valid` is not accepted.
  - After `run=1`, the order is preserved and pointers wrap correctly on subsequent pushes.
- Load 10, drop `run` at count 6 for 5 cycles:
  - `enable=0` and the count holds at 6.
  - On resume the count continues to 0.
  - `period_done` comes 6 RUN cycles after resume.
- Queue 7, 7, abort at count 4:
  - CLEAR strobes `valid` with `value=0`.
  - `level=0` and no `period_done`.
  - State is IDLE.
  - A push coincident with `abort` is rejected.
- With `TIMER_PERIOD_SEQ_REPEAT_EN`, push a single 3:
  - Periodic `period_done` every 5 cycles until `run=0`.
  - Without the macro, exactly one pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the countdown timer and its period sequencer.
package timer_pkg;
  localparam int TIMER_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    CLEAR = 2'd3
  } seq_state_t;
endpackage

// File: rtl/timer_period_fifo.sv
// Circular WIDTH x DEPTH period queue; DEPTH must be a power of two so the
// pointers wrap naturally. Flush empties the queue on the clock edge.
module timer_period_fifo
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [WIDTH-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/timer_period_seq.sv
// Period sequencer feeding the countdown timer's value/valid/enable inputs.
// Optional TIMER_PERIOD_SEQ_REPEAT_EN: repeat the last period once the queue drains.
module timer_period_seq
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_period,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         run,
  input  logic                         abort,
  input  logic [WIDTH-1:0]             timer_count,
  output logic [WIDTH-1:0]             value,
  output logic                         valid,
  output logic                         enable,
  output logic                         period_done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  seq_state_t       state_q, state_d;
  logic             full, empty, push, pop, done_d;
  logic             load_fifo;
  logic [WIDTH-1:0] head, last_period;

  assign in_ready = !full && !abort;
  assign push     = in_valid && in_ready;
  // Only pop when this LOAD was sourced from the queue, not a repeat.
  assign pop      = (state_q == LOAD) && load_fifo && !abort;
  assign enable   = (state_q == RUN) && run;

  timer_period_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   (in_period),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        IDLE:  if (run && !empty) state_d = LOAD;
        LOAD:  state_d = RUN;
        RUN: begin
          if (timer_count == '0) begin
            done_d = 1'b1;
            if (run && !empty) state_d = LOAD;
`ifdef TIMER_PERIOD_SEQ_REPEAT_EN
            else if (run)      state_d = LOAD;
`endif
            else               state_d = IDLE;
          end
        end
        CLEAR: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid       <= 1'b0;
      value       <= '0;
      period_done <= 1'b0;
      busy        <= 1'b0;
      load_fifo   <= 1'b0;
      last_period <= '0;
    end else begin
      valid       <= (state_d == LOAD) || (state_d == CLEAR);
      period_done <= done_d;
      busy        <= (state_d != IDLE);
      if (state_d == CLEAR) begin
        value <= '0;
      end else if (state_d == LOAD) begin
        value     <= empty ? last_period : head;
        load_fifo <= !empty;
      end
      if (pop) last_period <= head;
    end
  end
endmodule

// File: tb/tb_timer_period_seq.sv
// Directed bench for timer_period_seq with a behavioural countdown timer attached.
module tb_timer_period_seq;
  localparam int W  = 5;
  localparam int D  = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_period = '0;
  logic          in_valid = 1'b0, run = 1'b0, abort = 1'b0;
  logic          in_ready, valid, enable, period_done, busy;
  logic [W-1:0]  value, tcount;
  logic [LW-1:0] level;

  int tests = 0, fails = 0, cyc = 0;
  int sv_val[$], sv_cyc[$], dn_cyc[$];
  int s2[4] = '{2, 1, 0, 5};
  int s3[6] = '{11, 12, 13, 14, 16, 17};

  typedef struct {
    int iv, per, run, abt;
    int e_valid, e_value, e_en, e_done, e_busy, e_level, e_ready, e_cnt;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  timer_period_seq #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_period   (in_period),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .run         (run),
    .abort       (abort),
    .timer_count (tcount),
    .value       (value),
    .valid       (valid),
    .enable      (enable),
    .period_done (period_done),
    .busy        (busy),
    .level       (level)
  );

  // Countdown timer: load on valid, decrement while enabled, stop at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         tcount <= '0;
    else if (valid)                    tcount <= value;
    else if (enable && tcount != '0)   tcount <= tcount - 1'b1;
  end

  function automatic vec_t mk(int iv, int per, int rn, int abt, int ev, int eval,
                              int een, int ed, int eb, int el, int er, int ec);
    vec_t v;
    v.iv = iv; v.per = per; v.run = rn; v.abt = abt;
    v.e_valid = ev; v.e_value = eval; v.e_en = een; v.e_done = ed;
    v.e_busy = eb; v.e_level = el; v.e_ready = er; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      sv_val.push_back(int'(value));
      sv_cyc.push_back(cyc);
    end
    if (period_done) dn_cyc.push_back(cyc);
  endtask

  task automatic clear_sb();
    sv_val.delete();
    sv_cyc.delete();
    dn_cyc.delete();
  endtask

  task automatic push(input int p);
    int k;
    k = 0;
    in_period = W'(p);
    in_valid  = 1'b1;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    chk($sformatf("push %0d accepted", p), int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_run_cnt(input int c, input string nm);
    int k;
    k = 0;
    while (!(enable && int'(tcount) == c) && k < 100) begin
      tick();
      k++;
    end
    chk({nm, " reached count"}, int'(enable && int'(tcount) == c), 1);
  endtask

  task automatic cleanup();
    in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, k;
    tbl[0] = mk(1, 3, 1, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    tbl[1] = mk(0, 0, 1, 0,  1, 3, 0, 0, 1, 1, 1, 0);
    tbl[2] = mk(0, 0, 1, 0,  0, 3, 1, 0, 1, 0, 1, 3);
    tbl[3] = mk(0, 0, 1, 0,  0, 3, 1, 0, 1, 0, 1, 2);
    tbl[4] = mk(0, 0, 1, 0,  0, 3, 1, 0, 1, 0, 1, 1);
    tbl[5] = mk(0, 0, 1, 0,  0, 3, 1, 0, 1, 0, 1, 0);
    tbl[6] = mk(0, 0, 0, 0,  0, 3, 0, 1, 0, 0, 1, 0);
    tbl[7] = mk(0, 0, 0, 0,  0, 3, 0, 0, 0, 0, 1, 0);
    tbl[8] = mk(1, 4, 0, 1,  1, 0, 0, 0, 1, 0, 0, 0);
    tbl[9] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);

    // Reset values
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst valid", int'(valid), 0);
    chk("rst value", int'(value), 0);
    chk("rst enable", int'(enable), 0);
    chk("rst period_done", int'(period_done), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst level", int'(level), 0);
    chk("rst in_ready", int'(in_ready), 1);
    abort = 1'b1;
    #1;
    chk("rst in_ready abort", int'(in_ready), 0);
    abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Single period of 3, then abort with a coincident push
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].iv[0];
      in_period = W'(tbl[i].per);
      run       = tbl[i].run[0];
      abort     = tbl[i].abt[0];
      tick();
      chk($sformatf("row%0d valid", i), int'(valid), tbl[i].e_valid);
      chk($sformatf("row%0d value", i), int'(value), tbl[i].e_value);
      chk($sformatf("row%0d enable", i), int'(enable), tbl[i].e_en);
      chk($sformatf("row%0d period_done", i), int'(period_done), tbl[i].e_done);
      chk($sformatf("row%0d busy", i), int'(busy), tbl[i].e_busy);
      chk($sformatf("row%0d level", i), int'(level), tbl[i].e_level);
      chk($sformatf("row%0d in_ready", i), int'(in_ready), tbl[i].e_ready);
      chk($sformatf("row%0d count", i), int'(tcount), tbl[i].e_cnt);
    end
    in_valid = 1'b0;
    abort = 1'b0;

    // Back-to-back 2,1,0,5: order and load-to-done latency of period+2
    cleanup();
    clear_sb();
    run = 1'b1;
    push(2); push(1); push(0); push(5);
    k = 0;
    while (dn_cyc.size() < 4 && k < 200) begin tick(); k++; end
    chk("s2 four done pulses", int'(dn_cyc.size() >= 4), 1);
    chk("s2 four strobes", int'(sv_val.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (i < sv_val.size() && i < dn_cyc.size()) begin
        chk($sformatf("s2 strobe%0d value", i), sv_val[i], s2[i]);
        chk($sformatf("s2 period%0d latency", i), dn_cyc[i] - sv_cyc[i], s2[i] + 2);
      end
    end

    // Fill to depth while paused, reject a fifth, then drain in order with wrap
    cleanup();
    clear_sb();
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_period = W'(s3[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("s3 level full", int'(level), 4);
    chk("s3 in_ready full", int'(in_ready), 0);
    in_period = W'(15);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("s3 fifth rejected level", int'(level), 4);
    chk("s3 paused no load", int'(busy), 0);
    run = 1'b1;
    push(16);
    push(17);
    k = 0;
    while (sv_val.size() < 6 && k < 400) begin tick(); k++; end
    chk("s3 six strobes", int'(sv_val.size() >= 6), 1);
    for (int i = 0; i < 6; i++)
      if (i < sv_val.size()) chk($sformatf("s3 strobe%0d value", i), sv_val[i], s3[i]);

    // Pause at count 6 for 5 cycles, then resume to completion
    cleanup();
    clear_sb();
    run = 1'b1;
    push(10);
    wait_run_cnt(6, "s4");
    run = 1'b0;
    #1;
    chk("s4 enable paused", int'(enable), 0);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk($sformatf("s4 hold%0d count", t), int'(tcount), 6);
      chk($sformatf("s4 hold%0d done", t), int'(period_done), 0);
      chk($sformatf("s4 hold%0d busy", t), int'(busy), 1);
    end
    run = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk($sformatf("s4 resume%0d count", t), int'(tcount), (t <= 6) ? 6 - t : 0);
      chk($sformatf("s4 resume%0d done", t), int'(period_done), (t == 7) ? 1 : 0);
    end

    // Queue 7,7 and abort at count 4 with a coincident push
    cleanup();
    clear_sb();
    run = 1'b1;
    push(7);
    push(7);
    wait_run_cnt(4, "s5");
    abort = 1'b1;
    in_period = W'(9);
    in_valid = 1'b1;
    #1;
    chk("s5 in_ready during abort", int'(in_ready), 0);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("s5 clear valid", int'(valid), 1);
    chk("s5 clear value", int'(value), 0);
    chk("s5 clear level", int'(level), 0);
    chk("s5 clear busy", int'(busy), 1);
    tick();
    chk("s5 timer zeroed", int'(tcount), 0);
    chk("s5 idle busy", int'(busy), 0);
    chk("s5 idle valid", int'(valid), 0);
    tick();
    tick();
    tick();
    chk("s5 no period_done", dn_cyc.size(), 0);
    chk("s5 level after", int'(level), 0);

    // Single period of 3 with run held: repeats only when the macro is set
    cleanup();
    clear_sb();
    run = 1'b1;
    push(3);
    for (int t = 0; t < 30; t++) tick();
`ifdef TIMER_PERIOD_SEQ_REPEAT_EN
    chk("s6 repeating pulses", int'(dn_cyc.size() >= 4), 1);
    for (int i = 1; i < dn_cyc.size(); i++)
      chk($sformatf("s6 spacing%0d", i), dn_cyc[i] - dn_cyc[i-1], 5);
`else
    chk("s6 single pulse", dn_cyc.size(), 1);
`endif
    run = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    n = dn_cyc.size();
    for (int t = 0; t < 20; t++) tick();
    chk("s6 stopped after run low", dn_cyc.size(), n);

    // Async reset mid-period drops state and queued periods
    cleanup();
    clear_sb();
    run = 1'b1;
    push(5);
    push(6);
    wait_run_cnt(3, "s7");
    #2 reset = 1'b1;
    #1;
    chk("s7 reset busy", int'(busy), 0);
    chk("s7 reset level", int'(level), 0);
    chk("s7 reset valid", int'(valid), 0);
    chk("s7 reset value", int'(value), 0);
    chk("s7 reset enable", int'(enable), 0);
    #1 reset = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    chk("s7 queue lost busy", int'(busy), 0);
    chk("s7 queue lost level", int'(level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
